// File: rtl/imem_fetch_port.sv
// Instruction-memory responder: 32-word store, one-deep S1 address stage and a
// small response FIFO, with flush of wrong-path fetches and a program-load port.
module imem_fetch_port #(
  parameter int FIFO_DEPTH = 3,
  parameter int MEM_WORDS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_instr,
  output logic [15:0] rsp_pc,
  output logic        rsp_misalign,
  input  logic        prog_we,
  input  logic [4:0]  prog_addr,
  input  logic [15:0] prog_data
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // valid never depends on ready, and req_ready never credits a same-cycle pop.

  logic [15:0]   mem [MEM_WORDS];
  logic          s1_valid;
  logic [15:0]   s1_addr;
  logic [15:0]   fifo_instr [FIFO_DEPTH];
  logic [15:0]   fifo_pc    [FIFO_DEPTH];
  logic          fifo_mis   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          accept;
  logic          push;
  logic          pop;
  logic [15:0]   rd_word;
  logic [15:0]   push_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign occupancy  = {1'b0, count} + (CW+1)'(s1_valid);
  assign req_ready  = !reset && !flush && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign push       = s1_valid;
  assign rsp_valid  = (count != '0);
  assign pop        = rsp_valid && rsp_ready;

  // Address bits above the word index are ignored, so fetches wrap modulo 64 bytes.
  assign rd_word    = mem[s1_addr[IW:1]];
  assign push_instr = s1_addr[0] ? 16'h0000 : rd_word;

  assign rsp_instr    = rsp_valid ? fifo_instr[rd_ptr] : 16'h0000;
  assign rsp_pc       = rsp_valid ? fifo_pc[rd_ptr]    : 16'h0000;
  assign rsp_misalign = rsp_valid ? fifo_mis[rd_ptr]   : 1'b0;

  // Store is never reset; the S1 read above sees the pre-write value on a shared edge.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr[IW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= push_instr;
      fifo_pc[wr_ptr]    <= s1_addr;
      fifo_mis[wr_ptr]   <= s1_addr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_addr <= req_addr;
      if (push)   wr_ptr  <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr  <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed table, hand-written corner sequences and
// random traffic, all checked against an ordered expected-response queue.
module tb_imem_fetch_port;

  localparam int FIFO_DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, rsp_ready, prog_we;
  logic [15:0] req_addr, prog_data;
  logic [4:0]  prog_addr;
  logic        req_ready, rsp_valid, rsp_misalign;
  logic [15:0] rsp_instr, rsp_pc;

  imem_fetch_port #(.FIFO_DEPTH(FIFO_DEPTH), .MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc),
    .rsp_misalign(rsp_misalign), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  // exp_q entry: [33]=word already fetched, [32]=misalign, [31:16]=instr, [15:0]=pc
  logic [33:0] exp_q[$];
  logic [15:0] mm [32];
  int          checks, errors, n_acc, n_pop;
  logic [15:0] last_instr, last_pc;

  typedef struct {
    logic        rv;
    logic [15:0] addr;
    logic        e_ready;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs with the model, then advance model and DUT.
  task automatic step();
    logic        exp_ready, exp_valid, acc, pp;
    logic [33:0] h;
    #1;
    exp_ready = !reset && !flush && (exp_q.size() < FIFO_DEPTH);
    exp_valid = (exp_q.size() > 0) && exp_q[0][33];
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      h = exp_q[0];
      chk("rsp_pc", 64'(rsp_pc), 64'(h[15:0]));
      chk("rsp_instr", 64'(rsp_instr), 64'(h[31:16]));
      chk("rsp_misalign", 64'(rsp_misalign), 64'(h[32]));
    end else begin
      chk("rsp_idle_zero", 64'({rsp_misalign, rsp_instr, rsp_pc}), 64'(0));
    end
    acc = req_valid && exp_ready;
    pp  = exp_valid && rsp_ready;
    @(posedge clk);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (pp) begin
        h = exp_q.pop_front();
        n_pop++;
        last_instr = h[31:16];
        last_pc    = h[15:0];
      end
      foreach (exp_q[i]) begin
        h = exp_q[i];
        if (!h[33]) begin
          h[32]    = h[0];
          h[31:16] = h[0] ? 16'h0000 : mm[h[5:1]];
          h[33]    = 1'b1;
          exp_q[i] = h;
        end
      end
      if (acc) begin
        exp_q.push_back({2'b00, 16'h0000, req_addr});
        n_acc++;
      end
    end
    if (prog_we) mm[prog_addr] = prog_data;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("drain_bound", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic fetch(input logic [15:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int p0, a0;
    checks = 0; errors = 0; n_acc = 0; n_pop = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    rsp_ready = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    @(posedge clk); #1;
    chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_misalign, rsp_instr, rsp_pc}), 64'(0));

    // Program the whole store while reset is held.
    for (int i = 0; i < 32; i++) begin
      prog_we   = 1'b1;
      prog_addr = 5'(i);
      prog_data = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
      step();
    end
    prog_we = 1'b0;
    reset   = 1'b0;
    #1 chk("ready_after_reset", 64'(req_ready), 64'(1));

    // Back-to-back fetches with rsp_ready high: one response per cycle.
    tv[0] = '{1'b1, 16'd0, 1'b1, 1'b0, 16'h0000, 16'd0};
    tv[1] = '{1'b1, 16'd2, 1'b1, 1'b0, 16'h0000, 16'd0};
    tv[2] = '{1'b1, 16'd4, 1'b1, 1'b1, 16'h1111, 16'd0};
    tv[3] = '{1'b1, 16'd6, 1'b1, 1'b1, 16'h2222, 16'd2};
    tv[4] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'h3333, 16'd4};
    tv[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'h4444, 16'd6};
    tv[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'h0000, 16'd0};
    for (int i = 0; i < 7; i++) begin
      req_valid = tv[i].rv;
      req_addr  = tv[i].addr;
      #1;
      chk($sformatf("tv%0d_ready", i), 64'(req_ready), 64'(tv[i].e_ready));
      chk($sformatf("tv%0d_valid", i), 64'(rsp_valid), 64'(tv[i].e_valid));
      chk($sformatf("tv%0d_instr", i), 64'(rsp_instr), 64'(tv[i].e_instr));
      chk($sformatf("tv%0d_pc", i), 64'(rsp_pc), 64'(tv[i].e_pc));
      step();
    end
    req_valid = 1'b0;

    // Address wrap modulo 64 bytes.
    fetch(16'h0042);
    step();
    chk("wrap_instr", 64'(rsp_instr), 64'(16'h2222));
    chk("wrap_pc", 64'(rsp_pc), 64'(16'h0042));
    drain();

    // Misaligned fetch returns a NOP.
    fetch(16'h0003);
    step();
    chk("mis_instr", 64'(rsp_instr), 64'(16'h0000));
    chk("mis_flag", 64'(rsp_misalign), 64'(1));
    chk("mis_pc", 64'(rsp_pc), 64'(16'h0003));
    drain();

    // Backpressure: only FIFO_DEPTH of five requests get in.
    rsp_ready = 1'b0;
    a0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_addr  = 16'(8 + 2 * k);
      step();
    end
    req_valid = 1'b0;
    chk("bp_accepted", 64'(n_acc - a0), 64'(3));
    chk("bp_ready_low", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    p0 = n_pop;
    drain();
    chk("bp_drained", 64'(n_pop - p0), 64'(3));
    chk("bp_last_pc", 64'(last_pc), 64'(16'd12));
    #1 chk("bp_ready_back", 64'(req_ready), 64'(1));

    // Flush with two FIFO entries and S1 busy.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 16'(2 * k);
      step();
    end
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b1;
    p0 = n_pop;
    fetch(16'd6);
    drain();
    chk("flush_one_rsp", 64'(n_pop - p0), 64'(1));
    chk("flush_instr", 64'(last_instr), 64'(16'h4444));

    // Program write racing the S1 read of the same word.
    fetch(16'd4);
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 16'hBEEF;
    step();
    prog_we = 1'b0;
    chk("rbw_old", 64'(rsp_instr), 64'(16'h3333));
    step();
    fetch(16'd4);
    step();
    chk("rbw_new", 64'(rsp_instr), 64'(16'hBEEF));
    drain();

    // Reset mid-stream aborts in-flight fetches but keeps the store.
    rsp_ready = 1'b0;
    fetch(16'd0);
    fetch(16'd2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_outputs", 64'({rsp_valid, rsp_misalign, rsp_instr, rsp_pc}), 64'(0));
    rsp_ready = 1'b1;
    fetch(16'd4);
    step();
    chk("rst_store_kept", 64'(rsp_instr), 64'(16'hBEEF));
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 59) == 0);
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 5'($urandom);
      prog_data = 16'($urandom);
      step();
    end
    req_valid = 1'b0; flush = 1'b0; reset = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
